// File: rtl/hsv_mask_centroid.sv
// Per-frame pink/green mask accumulation; centroids are produced at end of
// frame by one shared restoring divider (sum / count, MSB first).
module hsv_mask_centroid #(
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int CW        = 19,
  parameter int SW        = 28,
  parameter int MIN_COUNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          sof,
  input  logic          eol,
  input  logic          eof,
  input  logic [31:0]   mask,
  output logic [XW-1:0] pink_x,
  output logic [YW-1:0] pink_y,
  output logic          pink_found,
  output logic [XW-1:0] green_x,
  output logic [YW-1:0] green_y,
  output logic          green_found,
  output logic          result_valid,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int BW = $clog2(SW);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_COUNT);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SW] ? '1 : s[SW-1:0];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a);
    return (&a) ? a : a + CW'(1);
  endfunction

  logic [XW-1:0] x_q, px;
  logic [YW-1:0] y_q, py;
  logic [1:0]    hit;
  logic          acc_clr, eof_q;
  // sum index: 0 pink x, 1 pink y, 2 green x, 3 green y
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [SW-1:0] sum_q [4];
  logic [SW-1:0] sum_d [4];
  logic [CW-1:0] snap_cnt_q [2];
  logic [SW-1:0] snap_sum_q [4];

  state_t        state_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] bit_q;
  logic [SW-1:0] dvd_q, quo_d;
  logic [CW-1:0] rem_q, divisor;
  logic [CW:0]   rem_sh, rem_d;
  logic          ge, pink_ok, green_ok;
  logic [XW-1:0] res_x_q [2];
  logic [YW-1:0] res_y_q [2];

  logic [XW-1:0] pink_x_q, green_x_q;
  logic [YW-1:0] pink_y_q, green_y_q;
  logic          pink_found_q, green_found_q, result_valid_q, overrun_q;
  logic          unused_ok;

  assign unused_ok = ^{mask[31:16], rem_d[CW]};

  assign px      = (in_valid && sof) ? '0 : x_q;
  assign py      = (in_valid && sof) ? '0 : y_q;
  assign hit     = {mask[15:8] == 8'hFF, mask[7:0] == 8'hFF};
  // Cycle after eof the eof-inclusive totals are snapshotted, so the live
  // accumulators restart from zero and may already take a new pixel.
  assign acc_clr = eof_q || (in_valid && sof);

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_d[c]       = acc_clr ? '0 : cnt_q[c];
      sum_d[2*c]     = acc_clr ? '0 : sum_q[2*c];
      sum_d[2*c+1]   = acc_clr ? '0 : sum_q[2*c+1];
      if (in_valid && hit[c]) begin
        cnt_d[c]     = sat_inc(cnt_d[c]);
        sum_d[2*c]   = sat_add(sum_d[2*c], SW'(px));
        sum_d[2*c+1] = sat_add(sum_d[2*c+1], SW'(py));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      eof_q <= 1'b0;
      for (int c = 0; c < 2; c++) cnt_q[c] <= '0;
      for (int s = 0; s < 4; s++) sum_q[s] <= '0;
    end else begin
      eof_q <= in_valid && eof;
      if (in_valid) begin
        if (eol) begin
          x_q <= '0;
          y_q <= py + YW'(1);
        end else begin
          x_q <= px + XW'(1);
          y_q <= py;
        end
      end
      for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
      for (int s = 0; s < 4; s++) sum_q[s] <= sum_d[s];
    end
  end

  assign divisor  = snap_cnt_q[idx_q[1]];
  assign rem_sh   = {rem_q, dvd_q[SW-1]};
  assign ge       = rem_sh >= {1'b0, divisor};
  assign rem_d    = ge ? rem_sh - {1'b0, divisor} : rem_sh;
  assign quo_d    = {dvd_q[SW-2:0], ge};
  assign pink_ok  = snap_cnt_q[0] >= MIN_C;
  assign green_ok = snap_cnt_q[1] >= MIN_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      bit_q          <= '0;
      dvd_q          <= '0;
      rem_q          <= '0;
      for (int c = 0; c < 2; c++) begin
        snap_cnt_q[c] <= '0;
        res_x_q[c]    <= '0;
        res_y_q[c]    <= '0;
      end
      for (int s = 0; s < 4; s++) snap_sum_q[s] <= '0;
      pink_x_q       <= '0;
      pink_y_q       <= '0;
      green_x_q      <= '0;
      green_y_q      <= '0;
      pink_found_q   <= 1'b0;
      green_found_q  <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      overrun_q      <= eof_q && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (eof_q) begin
            for (int c = 0; c < 2; c++) begin
              snap_cnt_q[c] <= cnt_q[c];
              res_x_q[c]    <= '0;
              res_y_q[c]    <= '0;
            end
            for (int s = 0; s < 4; s++) snap_sum_q[s] <= sum_q[s];
            rem_q <= '0;
            bit_q <= BIT_LAST;
            if (cnt_q[0] >= MIN_C) begin
              idx_q   <= 2'd0;
              dvd_q   <= sum_q[0];
              state_q <= DIV;
            end else if (cnt_q[1] >= MIN_C) begin
              idx_q   <= 2'd2;
              dvd_q   <= sum_q[2];
              state_q <= DIV;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d[CW-1:0];
          dvd_q <= quo_d;
          bit_q <= bit_q - BW'(1);
          if (bit_q == '0) begin
            if (idx_q[0]) res_y_q[idx_q[1]] <= quo_d[YW-1:0];
            else          res_x_q[idx_q[1]] <= quo_d[XW-1:0];
            rem_q <= '0;
            bit_q <= BIT_LAST;
            if (!idx_q[0]) begin
              idx_q <= idx_q + 2'd1;
              dvd_q <= snap_sum_q[idx_q + 2'd1];
            end else if (idx_q == 2'd1 && green_ok) begin
              idx_q <= 2'd2;
              dvd_q <= snap_sum_q[2];
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          pink_x_q       <= res_x_q[0];
          pink_y_q       <= res_y_q[0];
          green_x_q      <= res_x_q[1];
          green_y_q      <= res_y_q[1];
          pink_found_q   <= pink_ok;
          green_found_q  <= green_ok;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pink_x       = pink_x_q;
  assign pink_y       = pink_y_q;
  assign pink_found   = pink_found_q;
  assign green_x      = green_x_q;
  assign green_y      = green_y_q;
  assign green_found  = green_found_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == DIV);

endmodule

// File: tb/tb_hsv_mask_centroid.sv
// Bench for hsv_mask_centroid: two instances (MIN_COUNT=1 and default 16)
// share one pixel stream; results are checked against a frame-level model.
module tb_hsv_mask_centroid;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int SW = 28;

  logic clk = 1'b0;
  logic rst, in_valid, sof, eol, eof;
  logic [31:0] mask;
  logic [XW-1:0] a_px, a_gx, b_px, b_gx;
  logic [YW-1:0] a_py, a_gy, b_py, b_gy;
  logic a_pf, a_gf, a_rv, a_busy, a_ov;
  logic b_pf, b_gf, b_rv, b_busy, b_ov;

  hsv_mask_centroid #(.MIN_COUNT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eol(eol), .eof(eof), .mask(mask),
    .pink_x(a_px), .pink_y(a_py), .pink_found(a_pf), .green_x(a_gx), .green_y(a_gy),
    .green_found(a_gf), .result_valid(a_rv), .busy(a_busy), .overrun(a_ov));

  hsv_mask_centroid dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .eol(eol), .eof(eof), .mask(mask),
    .pink_x(b_px), .pink_y(b_py), .pink_found(b_pf), .green_x(b_gx), .green_y(b_gy),
    .green_found(b_gf), .result_valid(b_rv), .busy(b_busy), .overrun(b_ov));

  always #5 clk = ~clk;

  typedef struct {
    longint c0, c1, sx0, sx1, sy0, sy1;
    int     eof_cyc;
  } exp_t;

  typedef struct {
    logic [XW-1:0] px, gx;
    logic [YW-1:0] py, gy;
    logic          pf, gf;
    int            cyc;
  } res_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ova = 0, ovb = 0;
  exp_t expq[$];
  res_t qa[$], qb[$];

  // frame-level reference state
  int     mx, my;
  longint mc[2], msx[2], msy[2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    res_t r;
    if (a_rv === 1'b1) begin
      r.px = a_px; r.py = a_py; r.gx = a_gx; r.gy = a_gy; r.pf = a_pf; r.gf = a_gf; r.cyc = cyc;
      qa.push_back(r);
    end
    if (b_rv === 1'b1) begin
      r.px = b_px; r.py = b_py; r.gx = b_gx; r.gy = b_gy; r.pf = b_pf; r.gf = b_gf; r.cyc = cyc;
      qb.push_back(r);
    end
    if (a_ov === 1'b1) ova++;
    if (b_ov === 1'b1) ovb++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint cen(input longint s, input longint c, input int mn, input int w);
    if (c < mn || c == 0) return 0;
    return (s / c) % (64'sd1 <<< w);
  endfunction

  function automatic logic [7:0] rbyte();
    int v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: return 8'hFF;
      1: return 8'hFE;
      2: return 8'h7F;
      default: return v[7:0];
    endcase
  endfunction

  function automatic logic [7:0] miss_byte();
    case ($urandom_range(0, 2))
      0: return 8'hFE;
      1: return 8'h7F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int mode, input int x, input int y);
    logic [31:0] r;
    logic [7:0]  pb, gb;
    r  = $urandom;
    pb = 8'h00;
    gb = 8'h00;
    case (mode)
      0: begin pb = 8'hFF; gb = 8'hFF; end
      1: begin pb = rbyte(); gb = rbyte(); end
      2: begin pb = miss_byte(); gb = miss_byte(); end
      3: pb = (x >= 1 && x <= 2 && y >= 1 && y <= 2) ? 8'hFF : 8'h00;
      4: begin
        pb = (y == 10 && x < 20) ? 8'hFF : 8'h00;
        gb = (y == 50 && x >= 93 && x <= 107) ? 8'hFF : 8'h00;
      end
      5: begin
        pb = (y == 10 && x < 20) ? 8'hFF : 8'h00;
        gb = (y == 50 && x >= 92 && x <= 108 && x != 100) ? 8'hFF : 8'h00;
      end
      default: ;
    endcase
    return {r[31:16], gb, pb};
  endfunction

  task automatic clr_model();
    for (int c = 0; c < 2; c++) begin mc[c] = 0; msx[c] = 0; msy[c] = 0; end
  endtask

  task automatic pix(input bit s, input bit el, input bit ef, input logic [31:0] m);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; sof = s; eol = el; eof = ef; mask = m;
    if (s) begin mx = 0; my = 0; clr_model(); end
    if (m[7:0] == 8'hFF)  begin mc[0]++; msx[0] += mx; msy[0] += my; end
    if (m[15:8] == 8'hFF) begin mc[1]++; msx[1] += mx; msy[1] += my; end
    if (ef) begin
      e.c0 = mc[0]; e.c1 = mc[1]; e.sx0 = msx[0]; e.sx1 = msx[1];
      e.sy0 = msy[0]; e.sy1 = msy[1]; e.eof_cyc = cyc + 1;
      expq.push_back(e);
      clr_model();
    end
    if (el) begin mx = 0; my = (my + 1) % (1 << YW); end
    else mx = (mx + 1) % (1 << XW);
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    repeat (n) begin
      @(negedge clk);
      r = $urandom;
      in_valid = 1'b0; sof = r[0]; eol = r[1]; eof = r[2]; mask = $urandom;
    end
  endtask

  task automatic frame(input int w, input int h, input int mode, input bit use_sof, input int gap_pct);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
        pix(use_sof && x == 0 && y == 0, x == w - 1, x == w - 1 && y == h - 1, mk(mode, x, y));
      end
  endtask

  task automatic cmp(input string tag, input int mn, input res_t r, input exp_t e);
    longint ndiv;
    ndiv = 2 * longint'(e.c0 >= mn) + 2 * longint'(e.c1 >= mn);
    chk({tag, "_pink_x"},  64'(r.px), 64'(cen(e.sx0, e.c0, mn, XW)));
    chk({tag, "_pink_y"},  64'(r.py), 64'(cen(e.sy0, e.c0, mn, YW)));
    chk({tag, "_pink_f"},  64'(r.pf), 64'(e.c0 >= mn));
    chk({tag, "_green_x"}, 64'(r.gx), 64'(cen(e.sx1, e.c1, mn, XW)));
    chk({tag, "_green_y"}, 64'(r.gy), 64'(cen(e.sy1, e.c1, mn, YW)));
    chk({tag, "_green_f"}, 64'(r.gf), 64'(e.c1 >= mn));
    chk({tag, "_latency"}, 64'(r.cyc - e.eof_cyc), 64'(2 + SW * ndiv));
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    res_t r;
    int   k;
    k = 0;
    while ((qa.size() == 0 || qb.size() == 0) && k < 600) begin @(negedge clk); k++; end
    e = expq.pop_front();
    chk({tag, "_a_result_seen"}, 64'(qa.size() > 0), 64'd1);
    if (qa.size() > 0) begin r = qa.pop_front(); cmp({tag, "_a"}, 1, r, e); end
    chk({tag, "_b_result_seen"}, 64'(qb.size() > 0), 64'd1);
    if (qb.size() > 0) begin r = qb.pop_front(); cmp({tag, "_b"}, 16, r, e); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_outs"}, 64'({a_px, a_py, a_gx, a_gy, a_pf, a_gf, a_rv, a_busy, a_ov}), 64'd0);
    chk({tag, "_b_outs"}, 64'({b_px, b_py, b_gx, b_gy, b_pf, b_gf, b_rv, b_busy, b_ov}), 64'd0);
  endtask

  initial begin
    int ova0, ovb0, w, h;
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0; mask = '0;
    mx = 0; my = 0; clr_model();
    idle(3);
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    // 2x2 pink block in a 4x4 frame: centroid (1,1)
    frame(4, 4, 3, 1'b1, 0); idle(2);
    check_frame("blk4x4");

    // every pixel both colours: centroid is the frame centre
    frame(64, 48, 0, 1'b1, 0); idle(2);
    check_frame("full64x48");

    // 15 then 16 green hits around (100,50) against MIN_COUNT=16
    frame(110, 52, 4, 1'b1, 0); idle(2);
    check_frame("green15");
    frame(110, 52, 5, 1'b1, 0); idle(2);
    check_frame("green16");

    // near-miss mask bytes never count
    frame(8, 4, 2, 1'b1, 0); idle(2);
    check_frame("miss");

    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(3, 24);
      h = $urandom_range(2, 12);
      frame(w, h, 1, 1'b1, 15); idle(2);
      check_frame($sformatf("rand%0d", i));
    end

    // next frame starts the cycle after eof and without sof
    frame(4, 3, 1, 1'b1, 0);
    frame(16, 10, 1, 1'b0, 0); idle(2);
    check_frame("back2back_p");
    check_frame("back2back_q");

    // second eof 20 cycles after the first, during the division
    ova0 = ova; ovb0 = ovb;
    frame(8, 8, 0, 1'b1, 0);
    idle(15);
    chk("ovr_busy_a", 64'(a_busy), 64'd1);
    chk("ovr_busy_b", 64'(b_busy), 64'd1);
    frame(5, 1, 1, 1'b1, 0);
    void'(expq.pop_back());
    idle(200);
    check_frame("ovr_first");
    chk("ovr_pulses_a", 64'(ova - ova0), 64'd1);
    chk("ovr_pulses_b", 64'(ovb - ovb0), 64'd1);
    chk("ovr_no_extra_a", 64'(qa.size()), 64'd0);
    chk("ovr_no_extra_b", 64'(qb.size()), 64'd0);
    chk("idle_busy_a", 64'(a_busy), 64'd0);
    frame(12, 10, 0, 1'b1, 0); idle(2);
    check_frame("ovr_third");

    // reset in the middle of a division
    frame(8, 8, 0, 1'b1, 0);
    idle(30);
    @(negedge clk); rst = 1'b1;
    #1;
    chk_zero("midrst");
    void'(expq.pop_back());
    mx = 0; my = 0; clr_model();
    idle(3);
    @(negedge clk); rst = 1'b0;
    idle(150);
    chk("midrst_no_rv_a", 64'(qa.size()), 64'd0);
    chk("midrst_no_rv_b", 64'(qb.size()), 64'd0);
    frame(10, 6, 1, 1'b1, 10); idle(2);
    check_frame("after_rst");

    chk("total_overrun_a", 64'(ova), 64'd1);
    chk("total_overrun_b", 64'(ovb), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
